aes_enc_core: RTL and testbench

Iterative AES-128 encryption engine: the forward-direction counterpart to the decryption round chain. It accepts one 128-bit block plus a 1-bit tag, and performs the initial AddRoundKey, nine full rounds and the special final round (SubBytes, ShiftRows, AddRoundKey, no MixColumns) on a single shared round datapath. It pulls round keys by index from the existing round-key store and returns the ciphertext with the tag passed through unchanged. The 129-bit block format (bit 128 = tag) matches the decryption path, so ciphertext can be fed straight back into it.

---
 rtl/aes_enc_core.sv | 124 ++++++++++++
 tb/tb_aes_enc_core.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_enc_core.sv
// Iterative AES-128 encryption core: one shared round datapath, round keys fetched
// by index from an external key store, 1-bit tag carried alongside the block.
module aes_enc_core (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [128:0] data_in,
  input  logic [127:0] round_key,
  output logic [3:0]   key_idx,
  output logic         busy,
  output logic         done,
  output logic [128:0] data_out
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} fsm_e;

  // Forward S-box, entry x lives at bits [2047-8x -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  fsm_e         fsm_q;
  logic [127:0] state_q;
  logic         tag_q;
  logic [3:0]   round_q;
  logic [128:0] data_out_q;
  logic         done_q;

  logic [127:0] sb, sr, mc;
  logic [127:0] state_d, final_d;

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_sub
    assign sb[127-8*gi -: 8] = sbox(state_q[127-8*gi -: 8]);
  end

  // Byte gi sits in row gi%4, column gi/4; row r is rotated left by r columns.
  for (gi = 0; gi < 16; gi++) begin : g_shift
    localparam int R   = gi % 4;
    localparam int SRC = R + 4 * (((gi / 4) + R) % 4);
    assign sr[127-8*gi -: 8] = sb[127-8*SRC -: 8];
  end

  for (gi = 0; gi < 4; gi++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign a0 = sr[127-32*gi -: 8];
    assign a1 = sr[119-32*gi -: 8];
    assign a2 = sr[111-32*gi -: 8];
    assign a3 = sr[103-32*gi -: 8];
    assign mc[127-32*gi -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign mc[119-32*gi -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign mc[111-32*gi -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign mc[103-32*gi -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  assign state_d = mc ^ round_key;
  assign final_d = sr ^ round_key;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q      <= IDLE;
      state_q    <= '0;
      tag_q      <= 1'b0;
      round_q    <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (start) begin
            state_q <= data_in[127:0] ^ round_key;
            tag_q   <= data_in[128];
            round_q <= 4'd1;
            fsm_q   <= ROUND;
          end
        end
        ROUND: begin
          state_q <= state_d;
          round_q <= round_q + 4'd1;
          if (round_q == 4'd9) fsm_q <= FINAL;
        end
        FINAL: begin
          data_out_q <= {tag_q, final_d};
          done_q     <= 1'b1;
          round_q    <= '0;
          fsm_q      <= OUT;
        end
        OUT: begin
          done_q <= 1'b0;
          fsm_q  <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign key_idx  = round_q;
  assign busy     = (fsm_q != IDLE);
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_aes_enc_core.sv
// Randomised scoreboard bench for aes_enc_core with a byte-level AES model
// (S-box derived from GF(2^8) inversion, inverse cipher for round-trip checks).
module tb_aes_enc_core;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [128:0] data_in;
  logic [127:0] round_key;
  logic [3:0]   key_idx;
  logic         busy;
  logic         done;
  logic [128:0] data_out;

  always #5 clk = ~clk;

  aes_enc_core dut (
    .clk(clk), .n_rst(n_rst), .start(start), .data_in(data_in),
    .round_key(round_key), .key_idx(key_idx), .busy(busy), .done(done),
    .data_out(data_out)
  );

  typedef logic [0:15][7:0] blk_t;
  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic         tag;
    logic [127:0] ct;
  } exp_t;

  logic [7:0]   sbox_m [256];
  logic [7:0]   inv_m  [256];
  logic [127:0] rk_arr [11];
  exp_t         sb_q [$];
  int           errors = 0;
  int           checks = 0;

  assign round_key = (key_idx <= 4'd10) ? rk_arr[key_idx] : '0;

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_m[x] = s;
      inv_m[s]  = 8'(x);
    end
  endtask

  function automatic logic [127:0] round_key_of(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic blk_t sub_b(input blk_t s, input bit inv);
    blk_t r;
    for (int i = 0; i < 16; i++) r[i] = inv ? inv_m[s[i]] : sbox_m[s[i]];
    return r;
  endfunction

  function automatic blk_t shift_b(input blk_t s, input bit inv);
    blk_t r;
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++)
        r[row+4*c] = s[row + 4*(inv ? ((c - row + 4) % 4) : ((c + row) % 4))];
    return r;
  endfunction

  function automatic blk_t mix_b(input blk_t s, input bit inv);
    blk_t       r;
    logic [7:0] m [4];
    logic [7:0] acc;
    if (inv) begin m[0] = 8'd14; m[1] = 8'd11; m[2] = 8'd13; m[3] = 8'd9; end
    else     begin m[0] = 8'd2;  m[1] = 8'd3;  m[2] = 8'd1;  m[3] = 8'd1; end
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(m[(j - i + 4) % 4], s[4*c+j]);
        r[4*c+i] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
    blk_t s;
    s = pt ^ round_key_of(key, 0);
    for (int r = 1; r <= 10; r++) begin
      s = shift_b(sub_b(s, 1'b0), 1'b0);
      if (r < 10) s = mix_b(s, 1'b0);
      s = s ^ round_key_of(key, r);
    end
    return s;
  endfunction

  function automatic logic [127:0] dec(input logic [127:0] key, input logic [127:0] ct);
    blk_t s;
    s = ct ^ round_key_of(key, 10);
    for (int r = 9; r >= 0; r--) begin
      s = sub_b(shift_b(s, 1'b1), 1'b1);
      s = s ^ round_key_of(key, r);
      if (r > 0) s = mix_b(s, 1'b1);
    end
    return s;
  endfunction

  task automatic set_key(input logic [127:0] key);
    for (int r = 0; r <= 10; r++) rk_arr[r] = round_key_of(key, r);
  endtask

  // Drive a start request at the current negedge and record what must come back.
  task automatic issue(input logic [127:0] key, input logic [127:0] pt, input logic tag,
                       input logic [127:0] ct);
    exp_t e;
    set_key(key);
    data_in = {tag, pt};
    start   = 1'b1;
    e.key = key; e.pt = pt; e.tag = tag; e.ct = ct;
    sb_q.push_back(e);
  endtask

  // One block with cycle-exact key_idx/busy/done checks; returns at the IDLE negedge.
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt, input logic tag,
                           input logic [127:0] ct);
    issue(key, pt, tag, ct);
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      check($sformatf("timing c%0d", n), {key_idx, busy, done},
            {(n <= 10) ? 4'(n) : 4'd0, n <= 11, n == 11});
    end
  endtask

  task automatic idle_check(input int cycles, input logic [128:0] exp_out);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      check("idle", {key_idx, busy, done, data_out}, {4'd0, 1'b0, 1'b0, exp_out});
    end
  endtask

  always @(negedge clk) begin
    if (n_rst === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 with data_out %h, required no done", data_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("txn tag=%0d pt=%h ct=%h", e.tag, e.pt, data_out[127:0]);
        check("ciphertext", data_out, {e.tag, e.ct});
        check("round_trip", {data_out[128], dec(e.key, data_out[127:0])}, {e.tag, e.pt});
      end
    end
  end

  initial begin
    logic [127:0] k, p, x;
    n_rst   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    for (int r = 0; r <= 10; r++) rk_arr[r] = '0;
    init_sbox();
    #2;
    check("reset", {key_idx, busy, done, data_out}, '0);
    repeat (2) @(negedge clk);
    n_rst = 1'b1;

    idle_check(50, '0);
    @(negedge clk);
    run_block(KB, PB, 1'b0, CB);
    run_block(KC, PC, 1'b1, CC);
    idle_check(10, {1'b1, CC});

    // start held high for 14 edges; data changes mid-flight; only IDLE re-accepts.
    x = {$urandom, $urandom, $urandom, $urandom};
    issue(KB, PB, 1'b0, CB);
    @(posedge clk);
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (n == 3)  data_in = {1'b1, x};
      if (n == 12) begin
        exp_t e;
        e.key = KB; e.pt = x; e.tag = 1'b1; e.ct = enc(KB, x);
        sb_q.push_back(e);
      end
      if (n == 14) start = 1'b0;
      check($sformatf("held_start c%0d", n), {busy, done},
            {!(n == 12 || n == 24), (n == 11 || n == 23)});
    end

    // Reset in the middle of a block.
    issue(KC, PC, 1'b1, CC);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_rst = 1'b0;
    void'(sb_q.pop_back());
    #1;
    check("reset_midop", {key_idx, busy, done, data_out}, '0);
    @(negedge clk);
    n_rst = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      check("post_reset", {key_idx, busy, done, data_out}, '0);
    end
    run_block(KC, PC, 1'b1, CC);

    for (int i = 0; i < 1000; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      run_block(k, p, 1'($urandom), enc(k, p));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 160'(sb_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
